// File: rtl/alu_pkg.sv
// Shared opcode, FSM-state and iteration-counter definitions for alu_seq_core.
// ALU_SEQ_DIV_EN selects whether opcode 011 runs on the iterative divider.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MUL = 3'b010,
    OP_DIV = 3'b011,
    OP_AND = 3'b100,
    OP_OR  = 3'b101,
    OP_XOR = 3'b110,
    OP_RSV = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    ITER = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic int iter_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

  function automatic logic is_iter_op(input op_e op);
`ifdef ALU_SEQ_DIV_EN
    return (op == OP_MUL) || (op == OP_DIV);
`else
    return (op == OP_MUL);
`endif
  endfunction

endpackage

// File: rtl/alu_seq_core_if.sv
// Request/response bundle between a requester and alu_seq_core.
interface alu_seq_core_if #(parameter int WIDTH = 8);
  logic                 start;
  logic [2:0]           op;
  logic [WIDTH-1:0]     in_a;
  logic [WIDTH-1:0]     in_b;
  logic [2*WIDTH-1:0]   result;
  logic [WIDTH-1:0]     rem;
  logic                 busy;
  logic                 done;
  logic                 err;

  modport master (
    output start, op, in_a, in_b,
    input  result, rem, busy, done, err
  );

  modport slave (
    input  start, op, in_a, in_b,
    output result, rem, busy, done, err
  );
endinterface

// File: rtl/alu_seq_muldiv.sv
// Iterative radix-2 shift-add multiplier / restoring divider on operand magnitudes.
// Divider datapath and its ports exist only when ALU_SEQ_DIV_EN is defined.
module alu_seq_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_i,
`ifdef ALU_SEQ_DIV_EN
  input  logic               div_i,
  output logic [WIDTH-1:0]   rem_o,
`endif
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               done_o,
  output logic [2*WIDTH-1:0] res_o
);

  localparam int CW = iter_cnt_w(WIDTH);

  logic               active_q, active_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mag_q, mag_d;
  logic               neg_res_q, neg_res_d;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_res;

  assign a_mag = a_i[WIDTH-1] ? (~a_i + 1'b1) : a_i;
  assign b_mag = b_i[WIDTH-1] ? (~b_i + 1'b1) : b_i;

  // Upper half accumulates the multiplicand; the multiplier shifts out of the low half.
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_q} : '0);

`ifdef ALU_SEQ_DIV_EN
  logic               div_q, div_d;
  logic               neg_rem_q, neg_rem_d;
  logic [WIDTH:0]     div_shift, div_trial;
  logic               div_ge;
  logic [2*WIDTH-1:0] quo_mag, quo_res;
  logic [WIDTH-1:0]   rem_mag;

  // Upper half is the partial remainder, lower half the dividend turning into the quotient.
  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, mag_q};
  assign div_ge    = (div_shift >= {1'b0, mag_q});
`endif

  always_comb begin
    active_d  = active_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mag_d     = mag_q;
    neg_res_d = neg_res_q;
`ifdef ALU_SEQ_DIV_EN
    div_d     = div_q;
    neg_rem_d = neg_rem_q;
`endif
    if (start_i) begin
      active_d  = 1'b1;
      cnt_d     = CW'(WIDTH);
      neg_res_d = a_i[WIDTH-1] ^ b_i[WIDTH-1];
      acc_d     = {{WIDTH{1'b0}}, b_mag};
      mag_d     = a_mag;
`ifdef ALU_SEQ_DIV_EN
      div_d     = div_i;
      neg_rem_d = a_i[WIDTH-1];
      if (div_i) begin
        acc_d = {{WIDTH{1'b0}}, a_mag};
        mag_d = b_mag;
      end
`endif
    end else if (active_q) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
`ifdef ALU_SEQ_DIV_EN
        if (div_q) begin
          acc_d = {(div_ge ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                   acc_q[WIDTH-2:0], div_ge};
        end
`endif
      end else begin
        active_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active_q  <= 1'b0;
      cnt_q     <= '0;
      acc_q     <= '0;
      mag_q     <= '0;
      neg_res_q <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
      div_q     <= 1'b0;
      neg_rem_q <= 1'b0;
`endif
    end else begin
      active_q  <= active_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mag_q     <= mag_d;
      neg_res_q <= neg_res_d;
`ifdef ALU_SEQ_DIV_EN
      div_q     <= div_d;
      neg_rem_q <= neg_rem_d;
`endif
    end
  end

  assign done_o  = active_q && (cnt_q == '0);
  assign mul_res = neg_res_q ? (~acc_q + 1'b1) : acc_q;

`ifdef ALU_SEQ_DIV_EN
  assign quo_mag = {{WIDTH{1'b0}}, acc_q[WIDTH-1:0]};
  assign quo_res = neg_res_q ? (~quo_mag + 1'b1) : quo_mag;
  assign rem_mag = acc_q[2*WIDTH-1:WIDTH];
  assign rem_o   = neg_rem_q ? (~rem_mag + 1'b1) : rem_mag;
  assign res_o   = div_q ? quo_res : mul_res;
`else
  assign res_o   = mul_res;
`endif

endmodule

// File: rtl/alu_seq_core.sv
// Sequenced ALU: single-cycle add/sub/logic, iterative signed mul/div.
// Define ALU_SEQ_DIV_EN to build the divider; otherwise opcode 011 reports err.
//
// state | meaning
// IDLE  | waiting for start
// EXEC  | operands captured; single-cycle ops resolve here
// ITER  | multiplier/divider iterating
// DONE  | results valid, done pulse; start here chains the next op
module alu_seq_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  alu_seq_core_if.slave bus
);

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               err_q, err_d;

  logic               accept, md_start, md_done;
  logic [2*WIDTH-1:0] md_res;
  logic [2*WIDTH-1:0] a_ext, b_ext, alu_res;
  logic               alu_err;

`ifdef ALU_SEQ_DIV_EN
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   md_rem;
`endif

  assign accept   = ((state_q == IDLE) || (state_q == DONE)) && bus.start;
  assign md_start = accept && is_iter_op(op_e'(bus.op));

  alu_seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk     (clk),
    .reset   (reset),
    .start_i (md_start),
`ifdef ALU_SEQ_DIV_EN
    .div_i   (op_e'(bus.op) == OP_DIV),
    .rem_o   (md_rem),
`endif
    .a_i     (bus.in_a),
    .b_i     (bus.in_b),
    .done_o  (md_done),
    .res_o   (md_res)
  );

  assign a_ext = {{WIDTH{a_q[WIDTH-1]}}, a_q};
  assign b_ext = {{WIDTH{b_q[WIDTH-1]}}, b_q};

  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    case (op_q)
      OP_ADD:  alu_res = a_ext + b_ext;
      OP_SUB:  alu_res = a_ext - b_ext;
      OP_AND:  alu_res = {{WIDTH{1'b0}}, a_q & b_q};
      OP_OR:   alu_res = {{WIDTH{1'b0}}, a_q | b_q};
      OP_XOR:  alu_res = {{WIDTH{1'b0}}, a_q ^ b_q};
      default: alu_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    err_d    = err_q;
`ifdef ALU_SEQ_DIV_EN
    rem_d    = rem_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept) begin
          state_d = EXEC;
          op_d    = op_e'(bus.op);
          a_d     = bus.in_a;
          b_d     = bus.in_b;
        end
      end
      EXEC: begin
        if (is_iter_op(op_q)) begin
          state_d = ITER;
        end else begin
          state_d  = DONE;
          result_d = alu_res;
          err_d    = alu_err;
`ifdef ALU_SEQ_DIV_EN
          rem_d    = '0;
`endif
        end
      end
      ITER: begin
        if (md_done) begin
          state_d  = DONE;
          result_d = md_res;
          err_d    = 1'b0;
`ifdef ALU_SEQ_DIV_EN
          rem_d    = (op_q == OP_DIV) ? md_rem : '0;
          // Divide-by-zero still runs the full iteration count, then reports err.
          if ((op_q == OP_DIV) && (b_q == '0)) begin
            result_d = '0;
            rem_d    = '0;
            err_d    = 1'b1;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
      rem_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      err_q    <= err_d;
`ifdef ALU_SEQ_DIV_EN
      rem_q    <= rem_d;
`endif
    end
  end

  assign bus.busy   = (state_q == EXEC) || (state_q == ITER);
  assign bus.done   = (state_q == DONE);
  assign bus.result = result_q;
  assign bus.err    = err_q;
`ifdef ALU_SEQ_DIV_EN
  assign bus.rem    = rem_q;
`else
  assign bus.rem    = '0;
`endif

endmodule

// File: tb/tb_alu_seq_core.sv
// Directed-vector bench for alu_seq_core at WIDTH=8, both divider build options.
module tb_alu_seq_core;

  logic clk;
  logic reset;

  alu_seq_core_if #(.WIDTH(8)) bus ();

  alu_seq_core #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] res;
    logic [7:0]  rem;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vecs[$];
  int   n_chk = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int lat;
    logic [15:0] res_seen;
    lat = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = v.op;
    bus.in_a  = v.a;
    bus.in_b  = v.b;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.op    = 3'b110;
    bus.in_a  = ~v.a;
    bus.in_b  = ~v.b;
    chk({nm, "_busy_e0"}, {31'd0, bus.busy}, 32'd1);
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.done) begin
        lat = k;
        break;
      end
      chk({nm, "_busy_run"}, {31'd0, bus.busy}, 32'd1);
    end
    chk({nm, "_lat"}, lat, v.lat);
    chk({nm, "_res"}, {16'd0, bus.result}, {16'd0, v.res});
    chk({nm, "_rem"}, {24'd0, bus.rem}, {24'd0, v.rem});
    chk({nm, "_err"}, {31'd0, bus.err}, {31'd0, v.err});
    chk({nm, "_busy_done"}, {31'd0, bus.busy}, 32'd0);
    res_seen = bus.result;
    @(posedge clk);
    @(negedge clk);
    chk({nm, "_pulse"}, {31'd0, bus.done}, 32'd0);
    chk({nm, "_hold_res"}, {16'd0, bus.result}, {16'd0, v.res});
    chk({nm, "_hold_err"}, {31'd0, bus.err}, {31'd0, v.err});
  endtask

  initial begin
    int lat;
    int extra;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = 3'b000;
    bus.in_a  = 8'h00;
    bus.in_b  = 8'h00;
    #2 reset = 1'b0;
    #1;
    chk("rst_result", {16'd0, bus.result}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_err", {31'd0, bus.err}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    vecs.push_back('{3'b000, 8'd100, 8'd50, 16'h0096, 8'h00, 1'b0, 1});
    vecs.push_back('{3'b001, 8'h80, 8'h7F, 16'hFF01, 8'h00, 1'b0, 1});
    vecs.push_back('{3'b001, 8'h03, 8'h05, 16'hFFFE, 8'h00, 1'b0, 1});
    vecs.push_back('{3'b000, 8'hFF, 8'hFF, 16'hFFFE, 8'h00, 1'b0, 1});
    vecs.push_back('{3'b000, 8'h7F, 8'h01, 16'h0080, 8'h00, 1'b0, 1});
    vecs.push_back('{3'b010, 8'hF9, 8'h0C, 16'hFFAC, 8'h00, 1'b0, 9});
    vecs.push_back('{3'b010, 8'h80, 8'h80, 16'h4000, 8'h00, 1'b0, 9});
    vecs.push_back('{3'b010, 8'h7F, 8'h7F, 16'h3F01, 8'h00, 1'b0, 9});
    vecs.push_back('{3'b010, 8'h05, 8'hFF, 16'hFFFB, 8'h00, 1'b0, 9});
    vecs.push_back('{3'b100, 8'hF0, 8'h3C, 16'h0030, 8'h00, 1'b0, 1});
    vecs.push_back('{3'b101, 8'hF0, 8'h3C, 16'h00FC, 8'h00, 1'b0, 1});
    vecs.push_back('{3'b110, 8'hF0, 8'h3C, 16'h00CC, 8'h00, 1'b0, 1});
    vecs.push_back('{3'b111, 8'h12, 8'h34, 16'h0000, 8'h00, 1'b1, 1});
    vecs.push_back('{3'b000, 8'h01, 8'h02, 16'h0003, 8'h00, 1'b0, 1});
`ifdef ALU_SEQ_DIV_EN
    vecs.push_back('{3'b011, 8'h9C, 8'h07, 16'hFFF2, 8'hFE, 1'b0, 9});
    vecs.push_back('{3'b011, 8'h64, 8'hF9, 16'hFFF2, 8'h02, 1'b0, 9});
    vecs.push_back('{3'b011, 8'h80, 8'hFF, 16'h0080, 8'h00, 1'b0, 9});
    vecs.push_back('{3'b011, 8'h07, 8'h07, 16'h0001, 8'h00, 1'b0, 9});
    vecs.push_back('{3'b011, 8'h05, 8'h00, 16'h0000, 8'h00, 1'b1, 9});
`else
    vecs.push_back('{3'b011, 8'h9C, 8'h07, 16'h0000, 8'h00, 1'b1, 1});
`endif

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("v%0d", i));

    // back-to-back: start held high across the first done pulse
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 3'b100;
    bus.in_a  = 8'hF0;
    bus.in_b  = 8'h3C;
    @(posedge clk);
    @(negedge clk);
    bus.op = 3'b101;
    @(posedge clk);
    @(negedge clk);
    chk("b2b_done1", {31'd0, bus.done}, 32'd1);
    chk("b2b_res1", {16'd0, bus.result}, 32'h0030);
    chk("b2b_busy1", {31'd0, bus.busy}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    chk("b2b_busy2", {31'd0, bus.busy}, 32'd1);
    chk("b2b_nodone", {31'd0, bus.done}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("b2b_done2", {31'd0, bus.done}, 32'd1);
    chk("b2b_res2", {16'd0, bus.result}, 32'h00FC);
    @(posedge clk);
    @(negedge clk);

    // start pulse during a MUL must be ignored
    bus.start = 1'b1;
    bus.op    = 3'b010;
    bus.in_a  = 8'hF9;
    bus.in_b  = 8'h0C;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    bus.start = 1'b1;
    bus.op    = 3'b000;
    bus.in_a  = 8'h01;
    bus.in_b  = 8'h01;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    lat = 0;
    for (int k = 5; k <= 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.done) begin
        lat = k;
        break;
      end
    end
    chk("ign_lat", lat, 9);
    chk("ign_res", {16'd0, bus.result}, 32'h0000FFAC);
    extra = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.done || bus.busy) extra++;
    end
    chk("ign_no_extra", extra, 0);

    // leave err set so the reset check below sees it cleared
    run_vec('{3'b111, 8'h00, 8'h00, 16'h0000, 8'h00, 1'b1, 1}, "rsv_pre");
    run_vec('{3'b000, 8'h70, 8'h05, 16'h0075, 8'h00, 1'b0, 1}, "add_pre");
    run_vec('{3'b111, 8'h00, 8'h00, 16'h0000, 8'h00, 1'b1, 1}, "rsv_pre2");

    // reset in the middle of a MUL
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 3'b010;
    bus.in_a  = 8'h80;
    bus.in_b  = 8'h80;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("mid_busy", {31'd0, bus.busy}, 32'd1);
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("mid_rst_err", {31'd0, bus.err}, 32'd0);
    chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("mid_rst_done", {31'd0, bus.done}, 32'd0);
    chk("mid_rst_res", {16'd0, bus.result}, 32'd0);
    chk("mid_rst_rem", {24'd0, bus.rem}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    extra = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.done || bus.busy) extra++;
    end
    chk("mid_no_done", extra, 0);
    run_vec('{3'b000, 8'h01, 8'h01, 16'h0002, 8'h00, 1'b0, 1}, "post_rst_add");

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_seq_core.md
ALU_SEQ_CORE -- requirements
Module: alu_seq_core

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits (legal 4..32).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request; sampled only when busy=0.
REQ-005 op  input  3  opcode: 000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 AND, 101 OR, 110 XOR, 111 reserved.
REQ-006 in_a  input  WIDTH  signed operand A / dividend.
REQ-007 in_b  input  WIDTH  signed operand B / divisor.
REQ-008 result  output  2*WIDTH  registered result.
REQ-009 rem  output  WIDTH  registered signed remainder (DIV only, else 0).
REQ-010 busy  output  1  operation in progress.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 err  output  1  registered error flag, valid with done, held until next done.

Function
REQ-013 FSM states IDLE, EXEC, ITER, DONE; IDLE->EXEC on start in IDLE or DONE; EXEC->DONE for non-MUL/DIV ops; EXEC->ITER for MUL/DIV; ITER->DONE after WIDTH iterations; DONE->IDLE without start.
REQ-014 Accept edge E0: op, in_a, in_b captured; busy=1 from E0.
REQ-015 ADD/SUB/logic/reserved: result, rem, err, done updated at E0+1 (latency 1).
REQ-016 MUL/DIV: one radix-2 iteration per cycle on operand magnitudes, sign fix-up at end; result, rem, err, done updated at E0+WIDTH+1.
REQ-017 busy=0 in the cycle done=1; start during that cycle accepted (back-to-back, no bubble).
REQ-018 start while busy=1 ignored; op/in_a/in_b changes while busy have no effect.
REQ-019 ADD/SUB: sign-extend operands to 2*WIDTH, full-precision result, no overflow possible.
REQ-020 MUL: full signed 2*WIDTH product.
REQ-021 DIV: quotient truncated toward zero, sign-extended to 2*WIDTH on result; rem carries dividend sign; (-2^(WIDTH-1))/(-1) yields +2^(WIDTH-1), err=0.
REQ-022 DIV by zero: result=0, rem=0, err=1, normal DIV latency.
REQ-023 AND/OR/XOR: bitwise on WIDTH bits, zero-extended to 2*WIDTH.
REQ-024 Reserved op 111: result=0, rem=0, err=1, latency 1.
REQ-025 result/rem/err hold their value between done pulses.

Reset
REQ-026 reset low: state IDLE, result=0, rem=0, busy=0, done=0, err=0, iteration counter 0, immediately (asynchronous).
REQ-027 reset asserted mid-operation aborts it; no done is produced for the aborted request.
REQ-028 Deassertion synchronous to clk; first start accepted on the first edge after release.

Configuration
REQ-029 Macro ALU_SEQ_DIV_EN defined: DIV implemented per REQ-021/022.
REQ-030 ALU_SEQ_DIV_EN undefined: no divider logic; op 011 treated as reserved (REQ-024, latency 1); rem tied 0.

Structure
REQ-031 Package alu_pkg holds opcode constants, FSM state encoding, and ITER count width function.
REQ-032 Iterative unit in sub-module alu_seq_muldiv (start/done handshake, shift-add multiply, restoring divide); top holds FSM, operand capture, single-cycle ops, output registers.

Verification (WIDTH=8)
REQ-033 ADD 100+50 at E0 -> result 0x0096, err=0, done at E0+1; SUB -128-127 -> 0xFF01.
REQ-034 MUL -7*12 -> result 0xFFAC, done at E0+9, busy 1 for E0..E0+8; MUL -128*-128 -> 0x4000.
REQ-035 DIV -100/7 -> result 0xFFF2, rem 0xFE; DIV -128/-1 -> result 0x0080, err=0; DIV 5/0 -> result 0, err=1 at E0+9.
REQ-036 Back-to-back: start held high, AND 0xF0&0x3C then OR -> results 0x0030 then 0x00FC on consecutive done pulses; start during MUL busy ignored.
REQ-037 reset low at E0+4 of MUL -> outputs all 0 immediately, no done; next ADD 1+1 -> 0x0002 at latency 1.
REQ-038 Build without ALU_SEQ_DIV_EN: op 011 and op 111 -> result 0, err=1, done at E0+1.
